// File: rtl/licznik_rozkazow_if.sv
// ============================================================================
// licznik_rozkazow_if : command, status and return-stack bus of the PC unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface licznik_rozkazow_if #(
  parameter int PC_ROZM = 8
);
  logic               en;
  logic               jump;
  logic               call;
  logic               ret;
  logic [PC_ROZM-1:0] addr;
  logic               blad_clr;
  logic               stos_full;
  logic               stos_empty;
  logic [PC_ROZM-1:0] stos_data;
  logic [PC_ROZM-1:0] pc;
  logic               push;
  logic               pop;
  logic               stos_MUX;
  logic [PC_ROZM-1:0] data_pc;
  logic               busy;
  logic               blad;

  // master: sequencer/environment side; slave: the program counter itself
  modport master (
    output en, jump, call, ret, addr, blad_clr, stos_full, stos_empty, stos_data,
    input  pc, push, pop, stos_MUX, data_pc, busy, blad
  );

  modport slave (
    input  en, jump, call, ret, addr, blad_clr, stos_full, stos_empty, stos_data,
    output pc, push, pop, stos_MUX, data_pc, busy, blad
  );
endinterface

`default_nettype wire

// File: rtl/licznik_rozkazow.sv
// ============================================================================
// licznik_rozkazow : program counter with CALL/RET sequencing and stack errors
// Rev 1.0
// ============================================================================
`default_nettype none

module licznik_rozkazow #(
  parameter int                 PC_ROZM    = 8,
  parameter logic [PC_ROZM-1:0] RESET_ADDR = '0
) (
  input  wire                   clk,
  input  wire                   rst,
  licznik_rozkazow_if.slave     bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_RET_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_ROZM-1:0] pc_q, pc_d;
  logic [PC_ROZM-1:0] pc_inc;
  logic               push_c;
  logic               pop_c;

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // ret > call > jump > en; losers in the same cycle are dropped
        if (bus.ret) begin
          if (bus.stos_empty) begin
            state_d = ST_ERR;
          end else begin
            pop_c   = 1'b1;
            state_d = ST_RET_WAIT;
          end
        end else if (bus.call) begin
          if (bus.stos_full) begin
            state_d = ST_ERR;
          end else begin
            push_c = 1'b1;
            pc_d   = bus.addr;
          end
        end else if (bus.jump) begin
          pc_d = bus.addr;
        end else if (bus.en) begin
          pc_d = pc_inc;
        end
      end
      ST_RET_WAIT: begin
        // stack data_out becomes valid the cycle after the pop strobe
        pc_d    = bus.stos_data;
        state_d = ST_RUN;
      end
      ST_ERR: begin
        if (bus.blad_clr) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // strobes are gated by reset so the stack sees nothing while it is held
  assign bus.push     = push_c & rst;
  assign bus.pop      = pop_c & rst;
  assign bus.stos_MUX = 1'b0;
  assign bus.data_pc  = pc_inc;
  assign bus.pc       = pc_q;
  assign bus.busy     = (state_q != ST_RUN);
  assign bus.blad     = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_licznik_rozkazow.sv
// ============================================================================
// tb_licznik_rozkazow : directed bench with a 5-deep behavioural return stack
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_licznik_rozkazow;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;

  licznik_rozkazow_if #(.PC_ROZM(8)) bus ();

  licznik_rozkazow #(.PC_ROZM(8), .RESET_ADDR(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // behavioural stack: output register loads on pop, valid the next cycle
  logic [7:0] stk [0:4];
  logic [2:0] sp;
  logic [7:0] stk_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= 3'd0;
      stk_out <= 8'h00;
    end else if (bus.push && sp < 3'd5) begin
      stk[sp] <= bus.data_pc;
      sp      <= sp + 3'd1;
    end else if (bus.pop && sp != 3'd0) begin
      stk_out <= stk[sp-3'd1];
      sp      <= sp - 3'd1;
    end
  end

  assign bus.stos_full  = (sp == 3'd5);
  assign bus.stos_empty = (sp == 3'd0);
  assign bus.stos_data  = stk_out;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic j, input logic c, input logic r,
                     input logic [7:0] a, input logic bc);
    @(negedge clk);
    bus.en = e; bus.jump = j; bus.call = c; bus.ret = r; bus.addr = a; bus.blad_clr = bc;
    #1;
  endtask

  task automatic do_ret(input logic [7:0] exp_pc, input string tag);
    drv(0, 0, 0, 1, 8'h00, 0);
    chk({tag, "_pop"}, 16'(bus.pop), 16'h1);
    tick();
    drv(0, 0, 0, 0, 8'h00, 0);
    tick();
    chk({tag, "_pc"}, 16'(bus.pc), 16'(exp_pc));
    chk({tag, "_busy"}, 16'(bus.busy), 16'h0);
  endtask

  initial begin
    bus.en = 0; bus.jump = 0; bus.call = 0; bus.ret = 0; bus.addr = 0; bus.blad_clr = 0;
    #12;
    drv(1, 0, 0, 0, 8'h00, 0);
    rst = 1'b1;
    tick(); tick();
    chk("pre_reset_pc", 16'(bus.pc), 16'h02);

    // 1. asynchronous reset mid-cycle, with a call pending
    #2;
    bus.en = 0; bus.call = 1; bus.addr = 8'h33;
    rst = 1'b0;
    #1;
    chk("rst_pc", 16'(bus.pc), 16'h00);
    chk("rst_push", 16'(bus.push), 16'h0);
    chk("rst_pop", 16'(bus.pop), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_blad", 16'(bus.blad), 16'h0);
    tick();
    chk("rst_hold_pc", 16'(bus.pc), 16'h00);
    chk("rst_no_push", 16'(sp), 16'h0);
    drv(0, 0, 0, 0, 8'h00, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_pc", 16'(bus.pc), 16'h00);

    // 2. increment with wrap
    drv(0, 1, 0, 0, 8'hFE, 0);
    tick();
    chk("jump_pc", 16'(bus.pc), 16'hFE);
    drv(1, 0, 0, 0, 8'h00, 0);
    tick();
    chk("en_ff", 16'(bus.pc), 16'hFF);
    chk("data_pc_wrap", 16'(bus.data_pc), 16'h00);
    tick();
    chk("en_wrap", 16'(bus.pc), 16'h00);
    tick();
    chk("en_01", 16'(bus.pc), 16'h01);

    // 3. call: same-cycle push of pc+1, next pc = target
    drv(0, 1, 0, 0, 8'h10, 0);
    tick();
    chk("jump_10", 16'(bus.pc), 16'h10);
    drv(1, 1, 1, 0, 8'h40, 0);
    chk("call_push", 16'(bus.push), 16'h1);
    chk("call_data_pc", 16'(bus.data_pc), 16'h11);
    chk("call_mux", 16'(bus.stos_MUX), 16'h0);
    chk("call_no_pop", 16'(bus.pop), 16'h0);
    tick();
    chk("call_pc", 16'(bus.pc), 16'h40);
    chk("call_stack", 16'(stk[0]), 16'h11);

    // 4. ret with a simultaneous call: pop wins, call ignored during RET_WAIT
    drv(0, 0, 1, 1, 8'h77, 0);
    chk("ret_pop", 16'(bus.pop), 16'h1);
    chk("ret_call_nopush", 16'(bus.push), 16'h0);
    tick();
    chk("ret_busy", 16'(bus.busy), 16'h1);
    chk("ret_pc_held", 16'(bus.pc), 16'h40);
    drv(0, 0, 1, 0, 8'h77, 0);
    chk("retwait_nopush", 16'(bus.push), 16'h0);
    chk("retwait_nopop", 16'(bus.pop), 16'h0);
    tick();
    chk("ret_pc", 16'(bus.pc), 16'h11);
    chk("ret_busy_clr", 16'(bus.busy), 16'h0);

    // 5. underflow, commands ignored in ERR, clear
    drv(0, 0, 0, 1, 8'h00, 0);
    chk("uflow_nopop", 16'(bus.pop), 16'h0);
    tick();
    chk("uflow_blad", 16'(bus.blad), 16'h1);
    chk("uflow_busy", 16'(bus.busy), 16'h1);
    chk("uflow_pc", 16'(bus.pc), 16'h11);
    drv(0, 0, 1, 0, 8'h55, 0);
    chk("err_nopush", 16'(bus.push), 16'h0);
    tick();
    chk("err_pc", 16'(bus.pc), 16'h11);
    drv(0, 0, 0, 0, 8'h00, 1);
    tick();
    chk("clr_blad", 16'(bus.blad), 16'h0);
    chk("clr_busy", 16'(bus.busy), 16'h0);
    chk("clr_pc", 16'(bus.pc), 16'h11);

    // 6. fill the stack, overflow, then unwind LIFO
    drv(0, 0, 1, 0, 8'h20, 0); tick();
    drv(0, 0, 1, 0, 8'h30, 0); tick();
    drv(0, 0, 1, 0, 8'h40, 0); tick();
    drv(0, 0, 1, 0, 8'h50, 0); tick();
    drv(0, 0, 1, 0, 8'h60, 0); tick();
    chk("fill_pc", 16'(bus.pc), 16'h60);
    drv(0, 0, 1, 0, 8'h70, 0);
    chk("oflow_nopush", 16'(bus.push), 16'h0);
    tick();
    chk("oflow_blad", 16'(bus.blad), 16'h1);
    chk("oflow_pc", 16'(bus.pc), 16'h60);
    drv(0, 0, 0, 0, 8'h00, 1);
    tick();
    chk("oflow_clr", 16'(bus.blad), 16'h0);
    do_ret(8'h51, "lifo1");
    do_ret(8'h41, "lifo2");
    do_ret(8'h31, "lifo3");
    do_ret(8'h21, "lifo4");
    do_ret(8'h12, "lifo5");

    // reset during RET_WAIT discards the popped entry
    drv(0, 0, 1, 0, 8'h80, 0);
    tick();
    chk("call80_pc", 16'(bus.pc), 16'h80);
    drv(0, 0, 0, 1, 8'h00, 0);
    tick();
    chk("rw_busy", 16'(bus.busy), 16'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_rst_pc", 16'(bus.pc), 16'h00);
    chk("rw_rst_busy", 16'(bus.busy), 16'h0);
    drv(0, 0, 0, 0, 8'h00, 0);
    rst = 1'b1;
    tick();
    chk("rw_after_pc", 16'(bus.pc), 16'h00);
    chk("rw_after_busy", 16'(bus.busy), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
